// File: rtl/amba3_apb_arbiter.sv
// amba3_apb_arbiter
// Round-robin arbiter that shares one AMBA 3 APB master port between
// NUM_REQ single-transfer requesters. Each requester holds its request
// until it sees its one-cycle rsp_valid pulse.
//
// Optional feature: define AMBA3_APB_ARB_TIMEOUT_EN to abort transfers
// that wait more than TIMEOUT cycles for pready (rsp_err flags the abort).
// Without it, ACCESS waits indefinitely and rsp_err stays 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | bus idle, arbitrate among req_valid & ~rsp_valid
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase (psel=1, penable=1), wait for pready

module amba3_apb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_SIZE-1:0]           rsp_rdata,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [ADDR_SIZE-1:0]           paddr,
  output logic                           pwrite,
  output logic [DATA_SIZE-1:0]           pwdata,
  output logic                           psel,
  output logic                           penable,
  input  logic                           pready,
  input  logic [DATA_SIZE-1:0]           prdata
);

  localparam int GW = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Elaboration-time guard against unsupported parameter values
  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1) begin : g_bad_cfg
    $error("amba3_apb_arbiter: NUM_REQ must be 2..16 and TIMEOUT >= 1");
  end

  logic [1:0]           state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [ADDR_SIZE-1:0] paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [DATA_SIZE-1:0] pwdata_q, pwdata_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

`ifdef AMBA3_APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  // Down-counter loaded with TIMEOUT on entering ACCESS; reaching zero with
  // pready still low is the same point an up-count would hit TIMEOUT.
  logic [CW-1:0]        wait_cnt_q, wait_cnt_d;
`endif

  logic [NUM_REQ-1:0]   eligible;
  logic                 win_found;
  logic [GW-1:0]        win_idx;
  logic [GW-1:0]        scan_idx;

  // Round-robin pick: first eligible requester after the last grant, with wrap
  always_comb begin
    eligible  = req_valid & ~rsp_valid_q;
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = GW'((int'(grant_q) + k) % NUM_REQ);
      if (!win_found && eligible[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state logic for the sequencer, APB outputs and response pulse
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
`ifdef AMBA3_APB_ARB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d   = win_idx;
          paddr_d   = req_addr[win_idx*ADDR_SIZE +: ADDR_SIZE];
          pwrite_d  = req_write[win_idx];
          pwdata_d  = req_write[win_idx] ? req_wdata[win_idx*DATA_SIZE +: DATA_SIZE]
                                         : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef AMBA3_APB_ARB_TIMEOUT_EN
        wait_cnt_d = CW'(TIMEOUT);
`endif
      end

      ST_ACCESS: begin
        if (pready) begin
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          paddr_d              = '0;
          pwrite_d             = 1'b0;
          pwdata_d             = '0;
          rsp_valid_d[grant_q] = 1'b1;
          rsp_rdata_d          = pwrite_q ? '0 : prdata;
          state_d              = ST_IDLE;
        end
`ifdef AMBA3_APB_ARB_TIMEOUT_EN
        else if (wait_cnt_q == '0) begin
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          paddr_d              = '0;
          pwrite_d             = 1'b0;
          pwdata_d             = '0;
          rsp_valid_d[grant_q] = 1'b1;
          rsp_err_d            = 1'b1;
          state_d              = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset discards any
  // in-flight transfer without issuing a response
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= GW'(NUM_REQ - 1);
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef AMBA3_APB_ARB_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef AMBA3_APB_ARB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_amba3_apb_arbiter.sv
// Directed bench for amba3_apb_arbiter (NUM_REQ=4, 32-bit, TIMEOUT=16).
// Inputs are driven and outputs sampled on the falling edge.

module tb_amba3_apb_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              pclk = 1'b0;
  logic              preset_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic [AW-1:0]     paddr;
  logic              pwrite;
  logic [DW-1:0]     pwdata;
  logic              psel;
  logic              penable;
  logic              pready;
  logic [DW-1:0]     prdata;

  int n_checks = 0;
  int n_fail   = 0;

  amba3_apb_arbiter #(
    .NUM_REQ   (NR),
    .ADDR_SIZE (AW),
    .DATA_SIZE (DW),
    .TIMEOUT   (TO)
  ) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .psel      (psel),
    .penable   (penable),
    .pready    (pready),
    .prdata    (prdata)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    int order [5];
    logic [3:0] exp_rsp;
    order = '{0, 1, 2, 3, 0};

    preset_n  = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b1;
    prdata    = '0;

    // Reset values
    tick(); tick();
    check("rst_psel",      psel,      1'b0);
    check("rst_penable",   penable,   1'b0);
    check("rst_paddr",     paddr,     32'h0);
    check("rst_pwrite",    pwrite,    1'b0);
    check("rst_pwdata",    pwdata,    32'h0);
    check("rst_rsp_valid", rsp_valid, 4'b0000);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   rsp_err,   1'b0);
    check("rst_busy",      busy,      1'b0);
    preset_n = 1'b1;
    tick();
    check("idle_psel", psel, 1'b0);

    // Single write from requester 2
    set_req(2, 1'b1, 32'h10, 32'hDEADBEEF);
    req_valid = 4'b0100;
    tick();
    check("wr_setup_sel",  {psel, penable}, 2'b10);
    check("wr_paddr",      paddr,  32'h10);
    check("wr_pwrite",     pwrite, 1'b1);
    check("wr_pwdata",     pwdata, 32'hDEADBEEF);
    check("wr_busy",       busy,   1'b1);
    tick();
    check("wr_access_sel", {psel, penable}, 2'b11);
    tick();
    check("wr_rsp_valid",  rsp_valid, 4'b0100);
    check("wr_rsp_err",    rsp_err,   1'b0);
    check("wr_rsp_rdata",  rsp_rdata, 32'h0);
    check("wr_done_bus",   {psel, penable, pwrite}, 3'b000);
    check("wr_done_paddr", paddr, 32'h0);
    req_valid = 4'b0000;
    tick();
    check("wr_rsp_clear",  rsp_valid, 4'b0000);
    check("wr_idle_busy",  busy, 1'b0);

    // Read from requester 0 with three wait states
    pready = 1'b0;
    set_req(0, 1'b0, 32'h20, 32'hFFFFFFFF);
    req_valid = 4'b0001;
    tick();
    check("rd_setup_sel", {psel, penable}, 2'b10);
    check("rd_paddr",     paddr,  32'h20);
    check("rd_pwrite",    pwrite, 1'b0);
    check("rd_pwdata",    pwdata, 32'h0);
    tick();
    check("rd_access_sel", {psel, penable}, 2'b11);
    for (int w = 0; w < 3; w++) begin
      tick();
      check("rd_wait_sel", {psel, penable}, 2'b11);
      check("rd_wait_rsp", rsp_valid, 4'b0000);
    end
    pready = 1'b1;
    prdata = 32'h12345678;
    tick();
    check("rd_rsp_valid", rsp_valid, 4'b0001);
    check("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    check("rd_rsp_err",   rsp_err,   1'b0);
    check("rd_done_psel", psel,      1'b0);
    req_valid = 4'b0000;
    prdata = 32'hCAFEF00D;
    tick();
    check("rd_rdata_clear", rsp_rdata, 32'h0);

    // Re-grant guard: requester 1 keeps req_valid through its pulse
    set_req(1, 1'b1, 32'h44, 32'h0BADF00D);
    req_valid = 4'b0010;
    tick();
    check("rg_paddr1", paddr, 32'h44);
    tick();
    tick();
    check("rg_rsp1", rsp_valid, 4'b0010);
    tick();
    check("rg_gap_psel", psel, 1'b0);
    check("rg_gap_busy", busy, 1'b0);
    check("rg_gap_rsp",  rsp_valid, 4'b0000);
    tick();
    check("rg_regrant_sel", {psel, penable}, 2'b10);
    check("rg_paddr2",      paddr, 32'h44);
    tick();
    tick();
    check("rg_rsp2", rsp_valid, 4'b0010);
    req_valid = 4'b0000;
    tick();
    check("rg_idle", busy, 1'b0);

    // Reset in the middle of ACCESS
    pready = 1'b0;
    set_req(2, 1'b0, 32'h88, 32'h0);
    req_valid = 4'b0100;
    tick();
    check("mr_paddr", paddr, 32'h88);
    tick();
    check("mr_access", {psel, penable}, 2'b11);
    preset_n = 1'b0;
    tick();
    check("mr_bus",   {psel, penable, pwrite}, 3'b000);
    check("mr_paddr0", paddr, 32'h0);
    check("mr_rsp",   rsp_valid, 4'b0000);
    check("mr_busy",  busy, 1'b0);

    // Round robin with all four requesters pending from reset release
    for (int i = 0; i < NR; i++)
      set_req(i, (i % 2) == 1, 32'h100 + 32'(i * 4), 32'hD0000000 + 32'(i));
    req_valid = 4'b1111;
    pready    = 1'b1;
    prdata    = 32'hCAFE0000;
    preset_n  = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("rr_setup_sel", {psel, penable}, 2'b10);
      check("rr_paddr",     paddr, 32'h100 + 32'(order[g] * 4));
      check("rr_pwdata",    pwdata, ((order[g] % 2) == 1) ? 32'hD0000000 + 32'(order[g]) : 32'h0);
      tick();
      check("rr_access_sel", {psel, penable}, 2'b11);
      tick();
      exp_rsp = 4'b0001 << order[g];
      check("rr_rsp_valid", rsp_valid, exp_rsp);
      check("rr_rsp_rdata", rsp_rdata, ((order[g] % 2) == 1) ? 32'h0 : 32'hCAFE0000);
      if (g == 4) req_valid = 4'b0000;
    end
    tick();
    check("rr_idle", busy, 1'b0);

    // Stalled slave: timeout abort, or an indefinite wait without the feature
    pready = 1'b0;
    prdata = 32'h55AA55AA;
    set_req(3, 1'b0, 32'h300, 32'h0);
    req_valid = 4'b1000;
    tick();
    check("to_paddr", paddr, 32'h300);
    tick();
    check("to_access", {psel, penable}, 2'b11);
`ifdef AMBA3_APB_ARB_TIMEOUT_EN
    for (int w = 0; w < TO; w++) begin
      tick();
      check("to_wait", {psel, penable, rsp_valid}, {2'b11, 4'b0000});
    end
    tick();
    check("to_abort_rsp",   rsp_valid, 4'b1000);
    check("to_abort_err",   rsp_err,   1'b1);
    check("to_abort_rdata", rsp_rdata, 32'h0);
    check("to_abort_bus",   {psel, penable}, 2'b00);
    req_valid = 4'b0000;
    tick();
    check("to_err_clear", {rsp_err, busy}, 2'b00);
`else
    for (int w = 0; w < 100; w++) begin
      tick();
      check("to_hold", {psel, penable, rsp_valid}, {2'b11, 4'b0000});
    end
    pready = 1'b1;
    tick();
    check("to_late_rsp",   rsp_valid, 4'b1000);
    check("to_late_err",   rsp_err,   1'b0);
    check("to_late_rdata", rsp_rdata, 32'h55AA55AA);
    req_valid = 4'b0000;
    tick();
    check("to_late_idle", busy, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
